// File: rtl/ysyx_22040000_rf_wb_arbiter.sv
// Round-robin arbiter for the shared register-file write port (EXU vs LSU).
// Also tracks per-register busy state, which drives the issue hazard checks.
module ysyx_22040000_rf_wb_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [AWIDTH-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [AWIDTH-1:0] raddr1,
  input  logic [AWIDTH-1:0] raddr2,
  output logic              raw_stall,
  input  logic              exu_valid,
  input  logic [AWIDTH-1:0] exu_rd,
  input  logic [DWIDTH-1:0] exu_data,
  output logic              exu_ready,
  input  logic              lsu_valid,
  input  logic [AWIDTH-1:0] lsu_rd,
  input  logic [DWIDTH-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              rf_wen,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  output logic              idle
);

  localparam int NREG = 2 ** AWIDTH;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e              last_q, last_d;
  logic              wen_q, wen_d;
  logic [AWIDTH-1:0] waddr_q, waddr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic exu_gnt;
  logic lsu_gnt;
  logic iss_fire;

  // On a tie the source that did not win last time takes the port.
  assign exu_gnt = exu_valid & (!lsu_valid | (last_q == SRC_LSU));
  assign lsu_gnt = lsu_valid & (!exu_valid | (last_q == SRC_EXU));

  assign exu_ready = exu_gnt;
  assign lsu_ready = lsu_gnt;

  assign iss_ready = !busy_q[iss_rd];
  assign iss_fire  = iss_valid & iss_ready & (iss_rd != '0);
  assign raw_stall = busy_q[raddr1] | busy_q[raddr2];
  assign idle      = (busy_q == '0) & !wen_q;

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  always_comb begin
    last_d  = last_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      exu_gnt: begin
        last_d  = SRC_EXU;
        wen_d   = (exu_rd != '0);
        waddr_d = exu_rd;
        wdata_d = exu_data;
      end
      lsu_gnt: begin
        last_d  = SRC_LSU;
        wen_d   = (lsu_rd != '0);
        waddr_d = lsu_rd;
        wdata_d = lsu_data;
      end
      default: ;
    endcase
  end

  // Clear before set so a same-edge reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (iss_fire) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= SRC_EXU;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      last_q  <= last_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040000_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter and busy scoreboard.
// Each scenario task drives vectors and checks hand-computed results.
module tb_ysyx_22040000_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        raw_stall;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22040000_rf_wb_arbiter #(.AWIDTH(5), .DWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .raddr1(raddr1), .raddr2(raddr2), .raw_stall(raw_stall),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data),
    .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .idle(idle)
  );

  task automatic quiet();
    iss_valid = 0; iss_rd = 0; raddr1 = 0; raddr2 = 0;
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic test_reset();
    quiet();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rf_wen !== 1'b0) begin
      n_err++; $display("FAIL reset_wen got %0h want 0", rf_wen);
    end
    n_cmp++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_wdat got %0h/%0h want 0/0", rf_waddr, rf_wdata);
    end
    n_cmp++;
    if (idle !== 1'b1 || raw_stall !== 1'b0 || iss_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_flags got idle=%0b stall=%0b rdy=%0b want 1/0/1",
               idle, raw_stall, iss_ready);
    end
    n_cmp++;
    if (exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready got %0b%0b want 00", exu_ready, lsu_ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_exu();
    @(negedge clk);
    exu_valid = 1; exu_rd = 5; exu_data = 7;
    #1;
    n_cmp++;
    if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL exu_grant got %0b%0b want 10", exu_ready, lsu_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'd7) begin
      n_err++;
      $display("FAIL exu_write got %0b/%0d/%0d want 1/5/7",
               rf_wen, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    exu_valid = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (rf_wen !== 1'b0 || idle !== 1'b1) begin
      n_err++;
      $display("FAIL exu_drop got wen=%0b idle=%0b want 0/1", rf_wen, idle);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_lsu;
    exp_lsu = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exu_valid = 1; exu_rd = 6; exu_data = 32'h100 + i;
      lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h200 + i;
      #1;
      n_cmp++;
      if (lsu_ready !== exp_lsu[i] || exu_ready !== !exp_lsu[i]) begin
        n_err++;
        $display("FAIL rr_grant%0d got e=%0b l=%0b want l=%0b",
                 i, exu_ready, lsu_ready, exp_lsu[i]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (rf_wen !== 1'b1 ||
          rf_waddr !== (exp_lsu[i] ? 5'd7 : 5'd6) ||
          rf_wdata !== (exp_lsu[i] ? 32'h200 + i : 32'h100 + i)) begin
        n_err++;
        $display("FAIL rr_write%0d got %0b/%0d/%0h", i, rf_wen,
                 rf_waddr, rf_wdata);
      end
    end
    @(negedge clk);
    quiet();
    @(posedge clk); #1;
    n_cmp++;
    if (rf_wen !== 1'b0) begin
      n_err++; $display("FAIL rr_end got %0b want 0", rf_wen);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    iss_valid = 1; iss_rd = 5;
    #1;
    n_cmp++;
    if (iss_ready !== 1'b1) begin
      n_err++; $display("FAIL sb_alloc got %0b want 1", iss_ready);
    end
    @(posedge clk);
    @(negedge clk);
    iss_valid = 0; raddr1 = 5;
    #1;
    n_cmp++;
    if (raw_stall !== 1'b1 || iss_ready !== 1'b0 || idle !== 1'b0) begin
      n_err++;
      $display("FAIL sb_busy got stall=%0b rdy=%0b idle=%0b want 1/0/0",
               raw_stall, iss_ready, idle);
    end
    exu_valid = 1; exu_rd = 5; exu_data = 9;
    @(posedge clk); #1;
    n_cmp++;
    if (raw_stall !== 1'b1 || rf_wen !== 1'b1) begin
      n_err++;
      $display("FAIL sb_nobypass got stall=%0b wen=%0b want 1/1",
               raw_stall, rf_wen);
    end
    @(negedge clk);
    exu_valid = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (raw_stall !== 1'b0 || iss_ready !== 1'b1 || idle !== 1'b1) begin
      n_err++;
      $display("FAIL sb_clear got stall=%0b rdy=%0b idle=%0b want 0/1/1",
               raw_stall, iss_ready, idle);
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_same_edge();
    @(negedge clk);
    exu_valid = 1; exu_rd = 5; exu_data = 32'hAB;
    @(posedge clk);
    @(negedge clk);
    exu_valid = 0;
    iss_valid = 1; iss_rd = 5;
    #1;
    n_cmp++;
    if (iss_ready !== 1'b1 || rf_wen !== 1'b1 || rf_waddr !== 5'd5) begin
      n_err++;
      $display("FAIL same_setup got rdy=%0b wen=%0b a=%0d want 1/1/5",
               iss_ready, rf_wen, rf_waddr);
    end
    @(negedge clk);
    iss_valid = 0; raddr2 = 5;
    #1;
    n_cmp++;
    if (raw_stall !== 1'b1 || iss_ready !== 1'b0) begin
      n_err++;
      $display("FAIL same_setwins got stall=%0b rdy=%0b want 1/0",
               raw_stall, iss_ready);
    end
    exu_valid = 1; exu_rd = 5; exu_data = 32'hCD;
    @(posedge clk);
    @(negedge clk);
    exu_valid = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (raw_stall !== 1'b0 || idle !== 1'b1) begin
      n_err++;
      $display("FAIL same_clear got stall=%0b idle=%0b want 0/1",
               raw_stall, idle);
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_x0();
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 0; lsu_data = 123;
    iss_valid = 1; iss_rd = 0;
    #1;
    n_cmp++;
    if (lsu_ready !== 1'b1 || iss_ready !== 1'b1) begin
      n_err++;
      $display("FAIL x0_ready got l=%0b i=%0b want 1/1",
               lsu_ready, iss_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rf_wen !== 1'b0 || idle !== 1'b1 || raw_stall !== 1'b0) begin
      n_err++;
      $display("FAIL x0_nowrite got wen=%0b idle=%0b stall=%0b want 0/1/0",
               rf_wen, idle, raw_stall);
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    iss_valid = 1; iss_rd = 3;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h55;
    raddr1 = 3;
    @(posedge clk); #1;
    n_cmp++;
    if (rf_wen !== 1'b1 || raw_stall !== 1'b1) begin
      n_err++;
      $display("FAIL ar_setup got wen=%0b stall=%0b want 1/1",
               rf_wen, raw_stall);
    end
    iss_valid = 0; lsu_valid = 0;
    #1;
    rst_n = 0;
    #1;
    n_cmp++;
    if (rf_wen !== 1'b0 || raw_stall !== 1'b0 || idle !== 1'b1) begin
      n_err++;
      $display("FAIL ar_async got wen=%0b stall=%0b idle=%0b want 0/0/1",
               rf_wen, raw_stall, idle);
    end
    @(negedge clk);
    rst_n = 1;
    exu_valid = 1; exu_rd = 6; exu_data = 1;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 2;
    #1;
    n_cmp++;
    if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ar_lastgrant got e=%0b l=%0b want 0/1",
               exu_ready, lsu_ready);
    end
    @(negedge clk);
    quiet();
  endtask

  initial begin
    rst_n = 1;
    test_reset();
    test_single_exu();
    test_back_to_back();
    test_scoreboard();
    test_same_edge();
    test_x0();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
